// File: rtl/matmul_sequencer_pkg.sv
// Shared sizes, types and the lane-select helper for the matmul sequencer.
package matmul_sequencer_pkg;

  localparam int VLEN   = 128;
  localparam int N      = 4;
  localparam int ELEM_W = 32;
  localparam int ADDR_W = 5;
  localparam int ACC_W  = 2*ELEM_W + $clog2(N);
  localparam int IDX_W  = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  typedef logic [ELEM_W-1:0]         elem_t;
  typedef logic [ACC_W-1:0]          acc_t;
  typedef logic [IDX_W-1:0]          idx_t;
  typedef logic [ADDR_W-1:0]         addr_t;
  typedef logic [N-1:0][VLEN-1:0]    vec_set_t;

  // Lane k of one ROM vector; lane 0 sits in the least significant bits.
  function automatic elem_t lane(input logic [VLEN-1:0] v, input idx_t k);
    return v[k*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control, ROM read and result-stream signals of the matmul sequencer.
// slave = the sequencer side, master = the surrounding control/ROM/writeback.
interface matmul_sequencer_if;
  import matmul_sequencer_pkg::*;

  logic     start;
  addr_t    base_a;
  addr_t    base_b;
  logic     busy;
  logic     done;

  addr_t    rom_addr_a;
  addr_t    rom_addr_b;
  vec_set_t rom_vec_a;
  vec_set_t rom_vec_b;

  logic     res_valid;
  logic     res_ready;
  acc_t     res_data;
  idx_t     res_row;
  idx_t     res_col;

  modport slave (
    input  start, base_a, base_b, rom_vec_a, rom_vec_b, res_ready,
    output busy, done, rom_addr_a, rom_addr_b, res_valid, res_data, res_row, res_col
  );

  modport master (
    output start, base_a, base_b, rom_vec_a, rom_vec_b, res_ready,
    input  busy, done, rom_addr_a, rom_addr_b, res_valid, res_data, res_row, res_col
  );

endinterface

// File: rtl/matmul_sequencer_mac_unit.sv
// Single multiply-accumulate: one unsigned ELEM_W x ELEM_W product per enabled clock.
// Clear wins over enable so a new dot product can start on the same edge.
module mac_unit
  import matmul_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  input  elem_t a,
  input  elem_t b,
  output acc_t  acc
);

  logic [2*ELEM_W-1:0] prod;

  assign prod = a * b;

  // Accumulator register: cleared between elements, summed during MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// C = A x B sequencer: A rows and B columns come from the ROM as whole vector
// sets; each C element is a lane-serial dot product, streamed row-major.
//
//  state | meaning
//  IDLE  | waiting for start; bases and indices loaded on start
//  MAC   | one lane product per clock into the accumulator, k = 0..N-1
//  OUT   | C[i][j] presented on the result port until res_ready
//  DONE  | one-cycle done pulse, then back to IDLE
module matmul_sequencer
  import matmul_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  matmul_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MAC  = MAC;
  localparam logic [1:0] S_OUT  = OUT;
  localparam logic [1:0] S_DONE = DONE;
  localparam idx_t       LAST   = idx_t'(N-1);

  logic [1:0]      state_q;
  idx_t            i_q;
  idx_t            j_q;
  idx_t            k_q;
  addr_t           base_a_q;
  addr_t           base_b_q;

  logic [VLEN-1:0] vec_a_sel;
  logic [VLEN-1:0] vec_b_sel;
  elem_t           lane_a;
  elem_t           lane_b;
  logic            accept;
  logic            handshake;
  logic            mac_clr;
  logic            mac_en;
  acc_t            acc;

  assign vec_a_sel = bus.rom_vec_a[i_q];
  assign vec_b_sel = bus.rom_vec_b[j_q];
  assign lane_a    = lane(vec_a_sel, k_q);
  assign lane_b    = lane(vec_b_sel, k_q);

  assign accept    = (state_q == S_IDLE) && bus.start;
  assign handshake = (state_q == S_OUT) && bus.res_ready;
  assign mac_clr   = accept || handshake;
  assign mac_en    = (state_q == S_MAC);

  mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (lane_a),
    .b     (lane_b),
    .acc   (acc)
  );

  // Sequencing FSM with its row/column/lane indices and latched bases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            base_a_q <= bus.base_a;
            base_b_q <= bus.base_b;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            state_q  <= S_MAC;
          end
        end
        S_MAC: begin
          if (k_q == LAST) begin
            k_q     <= '0;
            state_q <= S_OUT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            if (j_q == LAST) begin
              j_q <= '0;
              if (i_q == LAST) begin
                i_q     <= '0;
                state_q <= S_DONE;
              end else begin
                i_q     <= i_q + 1'b1;
                state_q <= S_MAC;
              end
            end else begin
              j_q     <= j_q + 1'b1;
              state_q <= S_MAC;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q == S_MAC) || (state_q == S_OUT);
  assign bus.done       = (state_q == S_DONE);
  assign bus.res_valid  = (state_q == S_OUT);
  assign bus.res_data   = acc;
  assign bus.res_row    = i_q;
  assign bus.res_col    = j_q;
  assign bus.rom_addr_a = base_a_q;
  assign bus.rom_addr_b = base_b_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a ROM image (A rows at 0, B columns at 4, plus a
// random region) and a reference that forms each C element by plain arithmetic.
module tb_matmul_sequencer;
  import matmul_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [127:0] mem [32];
  logic [65:0]  got [16];

  matmul_sequencer_if bus ();

  matmul_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM: vector v of a read is the word at addr+v, wrapping at 32.
  always_comb begin
    logic [4:0] aa;
    logic [4:0] ab;
    bus.rom_vec_a = '0;
    bus.rom_vec_b = '0;
    aa = '0;
    ab = '0;
    for (int v = 0; v < N; v++) begin
      aa = bus.rom_addr_a + 5'(v);
      ab = bus.rom_addr_b + 5'(v);
      bus.rom_vec_a[v] = mem[aa];
      bus.rom_vec_b[v] = mem[ab];
    end
  end

  function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  // C[i][j] = sum over k of A[i][k]*B[j][k], A row i at ba+i, B column j at bb+j.
  function automatic logic [65:0] ref_c(input logic [4:0] ba, input logic [4:0] bb,
                                        input int i, input int j);
    logic [65:0]  s;
    logic [127:0] ra;
    logic [127:0] cb;
    s  = '0;
    ra = mem[5'(int'(ba) + i)];
    cb = mem[5'(int'(bb) + j)];
    for (int k = 0; k < 4; k++) s = s + 66'(ra[k*32 +: 32]) * 66'(cb[k*32 +: 32]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [4:0] ba, input logic [4:0] bb);
    bus.base_a = ba;
    bus.base_b = bb;
    bus.start  = 1'b1;
  endtask

  // Runs one multiply whose start is already driven; checks every handshake.
  // mode 0: ready=1; 1: random ready; 2: random + 10-cycle stall at C[1][2];
  // 3: ready=1 with a stray start pulse mid-run. chain re-asserts start in the
  // DONE cycle and leaves it high for the following IDLE cycle.
  task automatic do_run(input logic [4:0] ba, input logic [4:0] bb, input int mode, input bit chain);
    int          exp_idx;
    int          stall;
    int          first_v;
    int          done_cyc;
    bit          pend;
    bit          fin;
    bit          r;
    logic [65:0] hd;
    logic [1:0]  hr;
    logic [1:0]  hc;
    exp_idx = 0; stall = 0; first_v = -1; done_cyc = -1;
    pend = 0; fin = 0; r = 0; hd = '0; hr = '0; hc = '0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start = 1'b0;
        chk("busy_after_start", 128'(bus.busy), 128'(1));
        chk("rom_addr_a", 128'(bus.rom_addr_a), 128'(ba));
        chk("rom_addr_b", 128'(bus.rom_addr_b), 128'(bb));
      end
      if (mode == 3 && cyc == 20) kick(5'd8, 5'd9);
      if (mode == 3 && cyc == 21) bus.start = 1'b0;
      if (mode == 3 && cyc == 22) begin
        chk("stray_start_addr_a", 128'(bus.rom_addr_a), 128'(ba));
        chk("stray_start_addr_b", 128'(bus.rom_addr_b), 128'(bb));
        chk("stray_start_busy", 128'(bus.busy), 128'(1));
      end
      if (pend) begin
        chk("hold_valid", 128'(bus.res_valid), 128'(1));
        chk("hold_data", 128'(bus.res_data), 128'(hd));
        chk("hold_row", 128'(bus.res_row), 128'(hr));
        chk("hold_col", 128'(bus.res_col), 128'(hc));
      end
      if (bus.res_valid) begin
        if (first_v < 0) first_v = cyc;
        if (mode == 0 || mode == 3) r = 1'b1;
        else if (mode == 2 && bus.res_row == 2'd1 && bus.res_col == 2'd2 && stall < 10) begin
          r = 1'b0;
          stall++;
        end else r = 1'($urandom_range(0, 1));
        bus.res_ready = r;
        if (r) begin
          chk("res_row", 128'(bus.res_row), 128'(exp_idx / 4));
          chk("res_col", 128'(bus.res_col), 128'(exp_idx % 4));
          chk("res_data", 128'(bus.res_data), 128'(ref_c(ba, bb, exp_idx / 4, exp_idx % 4)));
          if (exp_idx < 16) got[exp_idx] = bus.res_data;
          exp_idx++;
          pend = 0;
        end else begin
          pend = 1;
          hd = bus.res_data;
          hr = bus.res_row;
          hc = bus.res_col;
        end
      end else begin
        bus.res_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (bus.done) begin
        done_cyc = cyc;
        fin = 1;
        chk("elements_at_done", 128'(exp_idx), 128'(16));
        chk("busy_in_done", 128'(bus.busy), 128'(0));
        if (chain) kick(ba, bb);
      end
    end
    chk("run_completed", 128'(fin), 128'(1));
    if (mode == 2) chk("stall_cycles", 128'(stall), 128'(10));
    if (mode == 0) begin
      chk("first_valid_latency", 128'(first_v), 128'(N + 1));
      chk("done_cycle", 128'(done_cyc), 128'(81));
    end
    @(negedge clk);
    chk("idle_busy", 128'(bus.busy), 128'(0));
    chk("single_done_pulse", 128'(bus.done), 128'(0));
    chk("idle_valid", 128'(bus.res_valid), 128'(0));
  endtask

  task automatic check_known_values(input string tag);
    chk({tag, "_c00"}, 128'(got[0]), 128'(60));
    chk({tag, "_c01"}, 128'(got[1]), 128'(140));
    chk({tag, "_c02"}, 128'(got[2]), 128'(50));
    chk({tag, "_c03"}, 128'(got[3]), 128'(130));
    chk({tag, "_c33"}, 128'(got[15]), 128'(706));
  endtask

  initial begin
    int ndone;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.res_ready = 1'b0;
    for (int a = 0; a < 32; a++) mem[a] = '0;
    mem[0] = pack4(1, 2, 3, 4);
    mem[1] = pack4(5, 6, 7, 8);
    mem[2] = pack4(9, 10, 11, 12);
    mem[3] = pack4(2, 30, 12, 20);
    mem[4] = pack4(2, 4, 6, 8);
    mem[5] = pack4(10, 12, 14, 16);
    mem[6] = pack4(5, 5, 5, 5);
    mem[7] = pack4(3, 4, 5, 26);
    for (int a = 16; a < 24; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_done", 128'(bus.done), 128'(0));
    chk("reset_valid", 128'(bus.res_valid), 128'(0));
    chk("reset_data", 128'(bus.res_data), 128'(0));
    chk("reset_addr_a", 128'(bus.rom_addr_a), 128'(0));
    chk("reset_addr_b", 128'(bus.rom_addr_b), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full run, no backpressure
    kick(5'd0, 5'd4);
    do_run(5'd0, 5'd4, 0, 1'b0);
    check_known_values("t1");

    // 2: random backpressure with a long stall at C[1][2]
    kick(5'd0, 5'd4);
    do_run(5'd0, 5'd4, 2, 1'b0);
    check_known_values("t2");

    // 3: stray start while busy
    kick(5'd0, 5'd4);
    do_run(5'd0, 5'd4, 3, 1'b0);
    check_known_values("t3");

    // 4: reset during the MAC phase of C[2][1]
    kick(5'd0, 5'd4);
    bus.res_ready = 1'b1;
    for (int cyc = 1; cyc <= 47; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
    end
    chk("abort_point_row", 128'(bus.res_row), 128'(2));
    chk("abort_point_col", 128'(bus.res_col), 128'(1));
    chk("abort_point_busy", 128'(bus.busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(bus.busy), 128'(0));
    chk("abort_data", 128'(bus.res_data), 128'(0));
    chk("abort_row", 128'(bus.res_row), 128'(0));
    chk("abort_col", 128'(bus.res_col), 128'(0));
    chk("abort_addr_b", 128'(bus.rom_addr_b), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.res_valid) ndone++;
    end
    chk("abort_quiet", 128'(ndone), 128'(0));
    kick(5'd0, 5'd4);
    do_run(5'd0, 5'd4, 0, 1'b0);
    chk("after_abort_c00", 128'(got[0]), 128'(60));

    // 5: zero region
    kick(5'd8, 5'd8);
    do_run(5'd8, 5'd8, 1, 1'b0);
    chk("zero_c00", 128'(got[0]), 128'(0));
    chk("zero_c33", 128'(got[15]), 128'(0));

    // 6: back-to-back runs, start also offered during DONE
    kick(5'd0, 5'd4);
    do_run(5'd0, 5'd4, 0, 1'b1);
    check_known_values("t6a");
    do_run(5'd0, 5'd4, 0, 1'b0);
    check_known_values("t6b");

    // random ROM contents, and an address window that wraps past 31
    kick(5'd16, 5'd20);
    do_run(5'd16, 5'd20, 1, 1'b0);
    kick(5'd30, 5'd2);
    do_run(5'd30, 5'd2, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
